// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
// MULDIV_ITER_MUL_EN selects the 32-cycle shift-add multiplier instead of a single-cycle one.
package muldiv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned DIV_CYCLES = 32;
`ifdef MULDIV_ITER_MUL_EN
  localparam int unsigned MUL_CYCLES = 32;
`else
  localparam int unsigned MUL_CYCLES = 1;
`endif

  // Bit positions inside the decoder's 2-bit op fields
  localparam int unsigned OP_MULT  = 0;
  localparam int unsigned OP_MULTU = 1;
  localparam int unsigned OP_DIV   = 0;
  localparam int unsigned OP_DIVU  = 1;
  localparam int unsigned OP_MFLO  = 0;
  localparam int unsigned OP_MFHI  = 1;
  localparam int unsigned OP_MTLO  = 0;
  localparam int unsigned OP_MTHI  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  // Magnitude of a two's-complement value when signed, else the raw value
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? XLEN'(-x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift, compare, subtract.
module div_step
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quot_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quot_out
);

  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] diff;

  assign shifted = {rem_in, quot_in[XLEN-1]};
  assign ge      = (shifted >= {1'b0, divisor});
  // When ge holds the true difference is below divisor, so the wrapped 32-bit result is exact
  assign diff    = shifted[XLEN-1:0] - divisor;

  assign rem_out  = ge ? diff : shifted[XLEN-1:0];
  assign quot_out = {quot_in[XLEN-2:0], ge};

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide unit: IDLE/MUL/DIV sequencer, 32-step restoring divider, MT/MF access.
// Define MULDIV_ITER_MUL_EN for a 32-cycle shift-add multiplier; default is single-cycle.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            op_valid,
  input  logic [1:0]      mult,
  input  logic [1:0]      div,
  input  logic [1:0]      mfhl,
  input  logic [1:0]      mthl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] mf_data
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [XLEN-1:0]  rem, quot, dvsr;
  logic             neg_q, neg_r;
  logic             any_op, accept;
  logic             start_mul, start_div, mul_done, div_done;
  logic [XLEN-1:0]  step_rem, step_quot;
  logic [2*XLEN-1:0] product;

  assign any_op  = |{mult, div, mfhl, mthl};
  assign busy    = (state != IDLE);
  assign stall   = op_valid & any_op & busy & ~flush;
  assign accept  = op_valid & ~busy & ~flush;
  assign mf_data = mfhl[OP_MFHI] ? hi : lo;

  div_step u_div_step (
    .rem_in  (rem),
    .quot_in (quot),
    .divisor (dvsr),
    .rem_out (step_rem),
    .quot_out(step_quot)
  );

`ifdef MULDIV_ITER_MUL_EN
  // Shift-add: rem holds the running upper half, quot the multiplier shifting out LSB-first
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_raw;
  assign mul_sum = {1'b0, rem} + (quot[0] ? {1'b0, dvsr} : {(XLEN+1){1'b0}});
  assign mul_raw = {mul_sum, quot[XLEN-1:1]};
  assign product = neg_q ? (2*XLEN)'(-mul_raw) : mul_raw;
`else
  logic sgn_mul;
  assign product = (2*XLEN)'({{XLEN{sgn_mul & quot[XLEN-1]}}, quot} *
                             {{XLEN{sgn_mul & dvsr[XLEN-1]}}, dvsr});
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, iteration counter and datapath strobes; flush overrides everything
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start_mul = 1'b0;
    start_div = 1'b0;
    mul_done  = 1'b0;
    div_done  = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (|mult) begin
              start_mul = 1'b1;
              state_nxt = MUL;
            end else if ((|div) && (src_b != '0)) begin
              start_div = 1'b1;
              state_nxt = DIV;
            end
          end
        end
        MUL: begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
            mul_done  = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        DIV: begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
            div_done  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand/iteration registers and architectural HI/LO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi    <= '0;
      lo    <= '0;
      rem   <= '0;
      quot  <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`ifndef MULDIV_ITER_MUL_EN
      sgn_mul <= 1'b0;
`endif
    end else begin
      if (accept && mthl[OP_MTHI]) hi <= src_a;
      if (accept && mthl[OP_MTLO]) lo <= src_a;

      if (start_div) begin
        rem   <= '0;
        quot  <= mag(src_a, div[OP_DIV]);
        dvsr  <= mag(src_b, div[OP_DIV]);
        neg_q <= div[OP_DIV] & (src_a[XLEN-1] ^ src_b[XLEN-1]);
        neg_r <= div[OP_DIV] & src_a[XLEN-1];
      end else if (state == DIV) begin
        rem  <= step_rem;
        quot <= step_quot;
      end

      if (div_done) begin
        lo <= neg_q ? XLEN'(-step_quot) : step_quot;
        hi <= neg_r ? XLEN'(-step_rem) : step_rem;
      end

`ifdef MULDIV_ITER_MUL_EN
      if (start_mul) begin
        rem   <= '0;
        quot  <= mag(src_a, mult[OP_MULT]);
        dvsr  <= mag(src_b, mult[OP_MULT]);
        neg_q <= mult[OP_MULT] & (src_a[XLEN-1] ^ src_b[XLEN-1]);
      end else if (state == MUL) begin
        rem  <= mul_sum[XLEN:1];
        quot <= {mul_sum[0], quot[XLEN-1:1]};
      end
`else
      if (start_mul) begin
        quot    <= src_a;
        dvsr    <= src_b;
        sgn_mul <= mult[OP_MULT];
      end
`endif

      if (mul_done) begin
        hi <= product[2*XLEN-1:XLEN];
        lo <= product[XLEN-1:0];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random ops vs. an arithmetic HI/LO model.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn, op_valid, flush;
  logic [1:0]  mult, div, mfhl, mthl;
  logic [31:0] src_a, src_b;
  logic        stall, busy;
  logic [31:0] hi, lo, mf_data;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [31:0] mh = '0;
  logic [31:0] ml = '0;

`ifdef MULDIV_ITER_MUL_EN
  localparam int MUL_LAT = 32;
`else
  localparam int MUL_LAT = 1;
`endif
  localparam int K_MULT = 0, K_MULTU = 1, K_DIV = 2, K_DIVU = 3;
  localparam int K_MTLO = 4, K_MTHI = 5, K_MFLO = 6, K_MFHI = 7;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid),
    .mult(mult), .div(div), .mfhl(mfhl), .mthl(mthl),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .stall(stall), .busy(busy), .hi(hi), .lo(lo), .mf_data(mf_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_op();
    op_valid = 1'b0;
    mult = 2'b00; div = 2'b00; mfhl = 2'b00; mthl = 2'b00;
  endtask

  task automatic set_op(input int kind, input logic [31:0] a, input logic [31:0] b);
    mult = 2'b00; div = 2'b00; mfhl = 2'b00; mthl = 2'b00;
    case (kind)
      K_MULT:  mult = 2'b01;
      K_MULTU: mult = 2'b10;
      K_DIV:   div  = 2'b01;
      K_DIVU:  div  = 2'b10;
      K_MTLO:  mthl = 2'b01;
      K_MTHI:  mthl = 2'b10;
      K_MFLO:  mfhl = 2'b01;
      default: mfhl = 2'b10;
    endcase
    src_a = a;
    src_b = b;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO pair
  function automatic void model(input int kind, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (kind)
      K_MULT:  begin p = 64'(sa * sb); mh = p[63:32]; ml = p[31:0]; end
      K_MULTU: begin p = {32'b0, a} * {32'b0, b}; mh = p[63:32]; ml = p[31:0]; end
      K_DIV:   if (b != 0) begin ml = 32'(sa / sb); mh = 32'(sa % sb); end
      K_DIVU:  if (b != 0) begin ml = a / b; mh = a % b; end
      K_MTLO:  ml = a;
      K_MTHI:  mh = a;
      default: ;
    endcase
  endfunction

  function automatic int latency(input int kind, input logic [31:0] b);
    if (kind == K_MULT || kind == K_MULTU) return MUL_LAT;
    if ((kind == K_DIV || kind == K_DIVU) && b != 0) return 32;
    return 0;
  endfunction

  task automatic run_op(input string tag, input int kind, input logic [31:0] a, input logic [31:0] b);
    int n;
    set_op(kind, a, b);
    op_valid = 1'b1;
    #1;
    check({tag, " stall_idle"}, 32'(stall), 32'd0);
    if (kind == K_MFLO) check({tag, " mf_lo"}, mf_data, ml);
    if (kind == K_MFHI) check({tag, " mf_hi"}, mf_data, mh);
    model(kind, a, b);
    tick();
    clear_op();
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check({tag, " busy_cycles"}, 32'(n), 32'(latency(kind, b)));
    check({tag, " hi"}, hi, mh);
    check({tag, " lo"}, lo, ml);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n;
    logic [31:0] a, b;
    resetn = 1'b1; flush = 1'b0; src_a = '0; src_b = '0;
    clear_op();
    #1 resetn = 1'b0;
    op_valid = 1'b1; mult = 2'b01;
    #1;
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst mf_data", mf_data, 32'h0);
    #20;
    check("rst held busy", 32'(busy), 32'd0);
    clear_op();
    @(negedge clk) resetn = 1'b1;
    tick();

    run_op("mult", K_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    check("mult hi const", hi, 32'hFFFF_FFFF);
    check("mult lo const", lo, 32'hFFFF_FFFE);
    run_op("multu", K_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    check("multu hi const", hi, 32'h0000_0001);
    check("multu lo const", lo, 32'hFFFF_FFFE);

    run_op("div", K_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div lo const", lo, 32'hFFFF_FFFD);
    check("div hi const", hi, 32'hFFFF_FFFF);
    run_op("divu", K_DIVU, 32'd100, 32'd7);
    check("divu lo const", lo, 32'h0000_000E);
    check("divu hi const", hi, 32'h0000_0002);

    // MFLO right behind a divide must stall for the whole divide
    set_op(K_DIV, 32'd1000, 32'hFFFF_FFFD);
    op_valid = 1'b1;
    model(K_DIV, 32'd1000, 32'hFFFF_FFFD);
    tick();
    set_op(K_MFLO, 32'h0, 32'h0);
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(posedge clk);
      #2;
    end
    check("mflo stall_cycles", 32'(n), 32'd32);
    check("mflo stall_clear", 32'(stall), 32'd0);
    check("mflo data", mf_data, ml);
    check("mflo quotient const", mf_data, 32'hFFFF_FEB3);
    tick();
    clear_op();

    run_op("mthi", K_MTHI, 32'h1234_5678, 32'h0);
    run_op("mtlo", K_MTLO, 32'h1234_5678, 32'h0);
    run_op("divu0", K_DIVU, 32'hCAFE_0001, 32'h0);
    check("divu0 hi const", hi, 32'h1234_5678);
    check("divu0 lo const", lo, 32'h1234_5678);
    tick();
    check("divu0 busy_after", 32'(busy), 32'd0);

    // Flush in divide iteration 10 with a concurrent MTHI
    set_op(K_DIV, 32'h7654_3210, 32'h0000_0013);
    op_valid = 1'b1;
    tick();
    clear_op();
    repeat (10) tick();
    set_op(K_MTHI, 32'hDEAD_BEEF, 32'h0);
    op_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flush stall_masked", 32'(stall), 32'd0);
    check("flush busy_before", 32'(busy), 32'd1);
    tick();
    flush = 1'b0;
    clear_op();
    check("flush busy_after", 32'(busy), 32'd0);
    check("flush hi", hi, mh);
    check("flush lo", lo, ml);
    repeat (3) tick();
    check("flush hi_later", hi, 32'h1234_5678);
    check("flush busy_later", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a divide
    set_op(K_DIV, 32'h8000_0000, 32'h0000_0003);
    op_valid = 1'b1;
    tick();
    clear_op();
    repeat (5) tick();
    #2 resetn = 1'b0;
    #1;
    mh = '0;
    ml = '0;
    check("arst hi", hi, 32'h0);
    check("arst lo", lo, 32'h0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst mf_data", mf_data, 32'h0);
    @(negedge clk) resetn = 1'b1;
    tick();
    run_op("multu_after_rst", K_MULTU, $urandom(), $urandom());

    for (int i = 0; i < 60; i++) begin
      a = pick();
      b = pick();
      run_op($sformatf("rnd%0d", i), int'($urandom_range(0, 7)), a, b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port op_valid, input, 1 bit: an instruction is presented this cycle.
REQ-004 SHALL have port mult, input, 2 bits: [0]=MULT, [1]=MULTU (decoder encoding); all four op fields are one-hot or zero.
REQ-005 SHALL have port div, input, 2 bits: [0]=DIV, [1]=DIVU.
REQ-006 SHALL have port mfhl, input, 2 bits: [0]=MFLO, [1]=MFHI.
REQ-007 SHALL have port mthl, input, 2 bits: [0]=MTLO, [1]=MTHI.
REQ-008 SHALL have ports src_a (rs) and src_b (rt), input, 32 bits each.
REQ-009 SHALL have port flush, input, 1 bit: abort any in-flight operation.
REQ-010 SHALL have port stall, output, 1 bit: the presented op is not accepted this cycle.
REQ-011 SHALL have port busy, output, 1 bit: a multiply or divide is in flight.
REQ-012 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO registers.
REQ-013 SHALL have port mf_data, output, 32 bits: read data for MFHI/MFLO.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV; busy = (state != IDLE).
REQ-015 SHALL define any_op = mult|div|mfhl|mthl nonzero, and stall = op_valid & any_op & busy & ~flush (combinational).
REQ-016 SHALL accept an op when op_valid & ~busy & ~flush; ops with any_op=0 never stall.
REQ-017 SHALL latch operands on MULT/MULTU accept and go IDLE->MUL; after 1 MUL cycle, write HI=product[63:32], LO=product[31:0] (signed for MULT, unsigned for MULTU) and return to IDLE.
REQ-018 SHALL go IDLE->DIV on DIV/DIVU accept with src_b!=0; run exactly 32 restoring iterations in DIV; on the 32nd iteration's edge write LO=quotient, HI=remainder and return to IDLE.
REQ-019 SHALL produce signed division on magnitudes, with quotient negated iff operand signs differ and remainder taking the sign of the dividend (truncating division).
REQ-020 SHALL treat a divide with src_b==0 as accepted, leave HI/LO unchanged, and stay in IDLE.
REQ-021 SHALL write HI (MTHI) or LO (MTLO) from src_a on the accept edge, with no busy.
REQ-022 SHALL drive mf_data = mfhl[1] ? hi : lo combinationally; the value is valid only when the op is not stalled.
REQ-023 SHALL, on flush, return to IDLE at the next edge, leave HI/LO unchanged, and drop any op presented in the same cycle (flush wins).
REQ-024 SHALL use a 5-bit iteration counter that wraps 31->0 only on the DIV->IDLE transition.

Reset
REQ-025 SHALL, while resetn=0, force state=IDLE, counter=0, hi=0, lo=0; busy=0, stall=0, and mf_data=0 follow from this.
REQ-026 SHALL make reset during MUL/DIV discard the operation; HI/LO read 0 after release.

Configuration
REQ-027 SHALL, when MULDIV_ITER_MUL_EN is defined, perform multiply as 32-cycle shift-add iterations in state MUL, reusing the divide counter (latency 32 cycles, sign handling as REQ-019 magnitude/negate).
REQ-028 SHALL, without MULDIV_ITER_MUL_EN, use a single-cycle MUL state with a synthesized 32x32 multiplier.

Structure
REQ-029 SHALL place the state enum, MUL_CYCLES/DIV_CYCLES constants and op-field bit indices in shared package muldiv_pkg.
REQ-030 SHALL place one divide iteration step (shift, compare, subtract) in sub-module div_step; all other logic stays in muldiv_ctrl.

Verification
REQ-031 SHALL verify: MULT 0xFFFFFFFF*0x00000002 -> HI=FFFFFFFF, LO=FFFFFFFE; MULTU same operands -> HI=00000001, LO=FFFFFFFE; busy for exactly 1 cycle (default build).
REQ-032 SHALL verify: DIV 0xFFFFFFF9/0x00000002 -> LO=FFFFFFFD, HI=FFFFFFFF, busy for exactly 32 cycles; DIVU 100/7 -> LO=0000000E, HI=00000002.
REQ-033 SHALL verify: MFLO presented the cycle after a DIV accept -> stall=1 for 32 cycles, then mf_data=quotient with stall=0.
REQ-034 SHALL verify: HI=LO=0x12345678 preloaded, then DIVU x/0 -> HI/LO unchanged, busy never asserted.
REQ-035 SHALL verify: flush on DIV iteration 10 -> busy=0 next cycle, HI/LO keep prior values, and a concurrent MTHI is dropped.
REQ-036 SHALL verify: resetn deasserted mid-DIV -> hi=lo=0, busy=0 immediately (asynchronous), and MULTU accepted normally after release.
